muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 164 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle fast paths for div-by-zero and overflow.
module muldiv_seq #(
    parameter int DW = 32,
    parameter int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [2:0]    func3_i,
    input  logic [DW-1:0] op_a_i,
    input  logic [DW-1:0] op_b_i,
    input  logic          flush_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LAST    = CW'(DW - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      func3_q, func3_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [DW-1:0]   opb_q, opb_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   result_q, result_d;

    logic            accept;
    logic            in_sign_a, in_sign_b;
    logic [DW-1:0]   in_mag_a, in_mag_b;
    logic            in_div_zero, in_ovf;
    logic [DW-1:0]   fast_res;

    logic [DW:0]     mul_sum;
    logic [DW:0]     rem_shift;
    logic            rem_ge;
    logic [DW-1:0]   rem_diff;
    logic [2*DW-1:0] step;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quot_fix, rem_fix;
    logic [DW-1:0]   fix_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Operand decode at accept: MULH/DIV/REM fully signed, MULHSU signed rs1 only.
    always_comb begin
        accept    = (state_q == IDLE) & valid_i & ~flush_i;
        in_sign_a = 1'b0;
        in_sign_b = 1'b0;
        case (func3_i)
            3'b001, 3'b100, 3'b110: begin
                in_sign_a = op_a_i[DW-1];
                in_sign_b = op_b_i[DW-1];
            end
            3'b010:  in_sign_a = op_a_i[DW-1];
            default: ;
        endcase
        in_mag_a    = in_sign_a ? -op_a_i : op_a_i;
        in_mag_b    = in_sign_b ? -op_b_i : op_b_i;
        in_div_zero = func3_i[2] & (op_b_i == '0);
        in_ovf      = func3_i[2] & ~func3_i[0] & (op_a_i == MIN_NEG) & (op_b_i == '1);
        if (in_div_zero)
            fast_res = func3_i[1] ? op_a_i : '1;
        else
            fast_res = func3_i[1] ? '0 : op_a_i;
    end

    // acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
        rem_ge    = rem_shift >= {1'b0, opb_q};
        rem_diff  = rem_shift[DW-1:0] - opb_q;
        if (func3_q[2])
            step = {rem_ge ? rem_diff : rem_shift[DW-1:0], acc_q[DW-2:0], rem_ge};
        else
            step = {mul_sum, acc_q[DW-1:1]};

        prod_fix = (sign_a_q ^ sign_b_q) ? -step : step;
        quot_fix = (sign_a_q ^ sign_b_q) ? -step[DW-1:0] : step[DW-1:0];
        rem_fix  = sign_a_q ? -step[2*DW-1:DW] : step[2*DW-1:DW];
        case (func3_q)
            3'b000:                 fix_res = prod_fix[DW-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DW-1:DW];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (in_div_zero | in_ovf) ? DONE : CALC;
            CALC: begin
                if (flush_i)
                    state_d = IDLE;
                else if (cnt_q == LAST)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (state_q == IDLE && accept) begin
            cnt_d    = '0;
            func3_d  = func3_i;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            opb_d    = in_mag_b;
            acc_d    = {{DW{1'b0}}, in_mag_a};
            if (in_div_zero | in_ovf)
                result_d = fast_res;
        end else if (state_q == CALC && !flush_i) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST)
                result_d = fix_res;
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = ((state_q == IDLE) & valid_i & ~flush_i) | (state_q == CALC);
        done_o  = (state_q == DONE);
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results and done cycles are queued at
// issue and checked against each done pulse.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  func3;
    logic [31:0] opA, opB;
    logic        flush;
    logic        ready, busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sbEntry_t;

    sbEntry_t    sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;
    int          expDone = 0;
    logic [31:0] lastExp = 32'h0;

    muldiv_seq #(.DW(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .func3_i(func3),
        .op_a_i(opA), .op_b_i(opB), .flush_i(flush),
        .ready_o(ready), .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // RV32M reference model in 64-bit arithmetic.
    function automatic logic [31:0] modelResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb2 = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        int q;
        case (f)
            3'b000: begin p = ua * ub;  return p[31:0];  end
            3'b001: begin p = sa * sb2; return p[63:32]; end
            3'b010: begin p = sa * ub;  return p[63:32]; end
            3'b011: begin p = ua * ub;  return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int modelLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            sbEntry_t e;
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", {31'h0, done}, 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("doneCycle", cyc, e.cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expv, input int lat, input bit expectDone,
                                 output int tAcc);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("readyTimeout", 32'h0, 32'h1);
        valid = 1'b1;
        func3 = f;
        opA   = a;
        opB   = b;
        tAcc  = cyc;
        if (expectDone) begin
            sb.push_back('{res: expv, cyc: cyc + lat});
            expDone++;
            lastExp = expv;
        end
        #1 checkOutput("busyAccept", {31'h0, busy}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("idleTimeout", 32'h0, 32'h1);
    endtask

    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat);
        int t;
        applyStimulus(f, a, b, expv, lat, 1'b1, t);
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        bit busyAll;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h1; corner[3] = 32'h80000000;

        rst = 1'b1; valid = 1'b0; flush = 1'b0; func3 = 3'b0; opA = '0; opB = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstReady", {31'h0, ready}, 32'h1);
        checkOutput("rstBusy", {31'h0, busy}, 32'h0);
        checkOutput("rstDone", {31'h0, done}, 32'h0);
        checkOutput("rstResult", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // MUL with busy/done timing
        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1, t);
        busyAll = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (busy !== 1'b1) busyAll = 1'b0;
            if (i < 32) @(negedge clk);
        end
        checkOutput("busyCalc", {31'h0, busyAll}, 32'h1);
        @(negedge clk);
        checkOutput("busyDone", {31'h0, busy}, 32'h0);
        checkOutput("readyDone", {31'h0, ready}, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("resultHeld", result, 32'hFFFFFFEB);

        runOp(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        runOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);

        runOp(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        runOp(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        runOp(3'b101, 32'd100, 32'd7, 32'd14, 33);
        runOp(3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Flush mid-DIV: no done, result keeps the previous value
        applyStimulus(3'b100, 32'd1000, 32'd3, 32'h0, 33, 1'b0, t);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushReady", {31'h0, ready}, 32'h1);
        checkOutput("flushDone", {31'h0, done}, 32'h0);
        checkOutput("flushResult", result, lastExp);
        repeat (40) @(negedge clk);
        checkOutput("flushResultLater", result, lastExp);

        runOp(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        runOp(3'b111, 32'd5, 32'd0, 32'd5, 1);
        runOp(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

        // Reset mid-MUL
        runOp(3'b000, 32'd3, 32'd5, 32'd15, 33);
        applyStimulus(3'b000, 32'd9, 32'd9, 32'h0, 33, 1'b0, t);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lastExp = 32'h0;
        checkOutput("midRstResult", result, 32'h0);
        checkOutput("midRstDone", {31'h0, done}, 32'h0);
        checkOutput("midRstReady", {31'h0, ready}, 32'h1);
        repeat (40) @(negedge clk);
        checkOutput("midRstResultLater", result, 32'h0);

        // Back-to-back with valid held high; second op appears in the DONE cycle
        valid = 1'b1; func3 = 3'b100; opA = 32'hFFFFFFF9; opB = 32'd2;
        t = cyc;
        sb.push_back('{res: 32'hFFFFFFFD, cyc: t + 33});
        expDone++;
        repeat (33) @(negedge clk);
        checkOutput("b2bReadyDone", {31'h0, ready}, 32'h0);
        func3 = 3'b110; opA = 32'd100; opB = 32'hFFFFFFF9;
        sb.push_back('{res: 32'd2, cyc: t + 67});
        expDone++;
        @(negedge clk);
        checkOutput("b2bReadyIdle", {31'h0, ready}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
        waitIdle();

        for (int i = 0; i < 20; i++) begin
            rf = 3'($urandom_range(7, 0));
            ra = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
            rb = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
            runOp(rf, ra, rb, modelResult(rf, ra, rb), modelLatency(rf, ra, rb));
        end

        repeat (5) @(negedge clk);
        checkOutput("sbEmpty", sb.size(), 32'h0);
        checkOutput("doneCount", doneCount, expDone);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
